// File: rtl/pio_svc_pkg.sv
// Shared definitions for the PIO irq service master: slave register map
// and the service FSM state encoding.
package pio_svc_pkg;

    localparam logic [1:0] PIO_DATA_OFS = 2'd0;
    localparam logic [1:0] PIO_MASK_OFS = 2'd2;
    localparam logic [1:0] PIO_EDGE_OFS = 2'd3;

    typedef enum logic [3:0] {
        RST,
        INIT,
        IDLE,
        RDE_A,
        RDE_D,
        CLR,
        RDD_A,
        RDD_D,
        EMIT,
        HOLD
    } svc_state_e;

endpackage

// File: rtl/pio_holdoff_timer.sv
// Hold-off down-counter: loaded when an event is accepted, decremented while
// the master sits in HOLD; done marks the last hold-off cycle.
module pio_holdoff_timer #(
    parameter logic [15:0] HOLDOFF_CYCLES = 16'd1000
) (
    input  logic clk,
    input  logic reset,
    input  logic load,
    input  logic dec,
    output logic done
);

    logic [15:0] cnt;

    // Load on event accept, count down to zero while holding off.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= 16'd0;
        end else if (load) begin
            cnt <= HOLDOFF_CYCLES;
        end else if (dec && cnt != 16'd0) begin
            cnt <= cnt - 16'd1;
        end
    end

    // Exiting on a count of 1 spends exactly HOLDOFF_CYCLES cycles in HOLD.
    assign done = (cnt == 16'd1);

endmodule

// File: rtl/pio_irq_service_master.sv
// Avalon-MM master servicing an edge-capturing PIO: programs the irq mask,
// then on each irq reads/clears the edge capture, reads the live level and
// emits one event on a valid/ready stream, followed by a debounce hold-off.
module pio_irq_service_master
    import pio_svc_pkg::*;
#(
    parameter int              DATA_W         = 1,
    parameter logic [DATA_W-1:0] IRQ_MASK     = DATA_W'(1),
    parameter logic [15:0]     HOLDOFF_CYCLES = 16'd1000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic              irq,
    output logic [1:0]        m_address,
    output logic              m_chipselect,
    output logic              m_write_n,
    output logic [31:0]       m_writedata,
    input  logic [31:0]       m_readdata,
    output logic              event_valid,
    input  logic              event_ready,
    output logic [DATA_W-1:0] event_edge,
    output logic [DATA_W-1:0] event_level,
    output logic [15:0]       event_count,
    output logic              busy
);

    svc_state_e        state;
    logic [DATA_W-1:0] edge_reg;
    logic [DATA_W-1:0] level_reg;
    logic [15:0]       evt_cnt;
    logic              hold_load;
    logic              hold_done;
    logic [DATA_W-1:0] rd_bits;
    logic              unused_rdata;

    assign rd_bits      = m_readdata[DATA_W-1:0];
    assign unused_rdata = ^m_readdata;

    assign hold_load = (state == EMIT) && event_ready && (HOLDOFF_CYCLES != 16'd0);

    pio_holdoff_timer #(
        .HOLDOFF_CYCLES(HOLDOFF_CYCLES)
    ) u_holdoff (
        .clk  (clk),
        .reset(reset),
        .load (hold_load),
        .dec  (state == HOLD),
        .done (hold_done)
    );

    // Service sequencer plus the captured event data and accept counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= RST;
            edge_reg  <= '0;
            level_reg <= '0;
            evt_cnt   <= 16'd0;
        end else begin
            case (state)
                RST:   state <= INIT;
                INIT:  state <= IDLE;
                IDLE:  if (en && irq) state <= RDE_A;
                RDE_A: state <= RDE_D;
                RDE_D: begin
                    edge_reg <= rd_bits;
                    // A zero edge capture means nothing to service.
                    state    <= (rd_bits == '0) ? IDLE : CLR;
                end
                CLR:   state <= RDD_A;
                RDD_A: state <= RDD_D;
                RDD_D: begin
                    level_reg <= rd_bits;
                    state     <= EMIT;
                end
                EMIT: begin
                    if (event_ready) begin
                        if (evt_cnt != 16'hFFFF) evt_cnt <= evt_cnt + 16'd1;
                        state <= (HOLDOFF_CYCLES != 16'd0) ? HOLD : IDLE;
                    end
                end
                HOLD:  if (hold_done) state <= IDLE;
                default: state <= RST;
            endcase
        end
    end

    // Bus signals decoded straight from the state register.
    always_comb begin
        m_chipselect = 1'b0;
        m_write_n    = 1'b1;
        m_address    = PIO_DATA_OFS;
        m_writedata  = 32'd0;
        case (state)
            INIT: begin
                m_chipselect = 1'b1;
                m_write_n    = 1'b0;
                m_address    = PIO_MASK_OFS;
                m_writedata  = 32'(IRQ_MASK);
            end
            RDE_A: begin
                m_chipselect = 1'b1;
                m_address    = PIO_EDGE_OFS;
            end
            RDE_D: m_address = PIO_EDGE_OFS;
            CLR: begin
                m_chipselect = 1'b1;
                m_write_n    = 1'b0;
                m_address    = PIO_EDGE_OFS;
                m_writedata  = 32'({DATA_W{1'b1}});
            end
            RDD_A: begin
                m_chipselect = 1'b1;
                m_address    = PIO_DATA_OFS;
            end
            default: ;
        endcase
    end

    assign event_valid = (state == EMIT);
    assign event_edge  = edge_reg;
    assign event_level = level_reg;
    assign event_count = evt_cnt;
    assign busy        = (state != IDLE);

endmodule
